// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: detects mispredicts, registers a PC redirect and
// holds an IF/ID flush window. Optional BRU_STATS_EN adds saturating counters.
module branch_resolve_unit #(
  parameter int size         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_pred_taken,
  input  logic            ex_cond,
  input  logic [size-1:0] ex_pc,
  input  logic [size-1:0] ex_imm,
  input  logic [size-1:0] ex_rs1,
  output logic            redirect_valid,
  output logic [size-1:0] redirect_pc,
  output logic            flush_if,
  output logic            flush_id,
  output logic            busy,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  // Only meaningful when FLUSH_CYCLES > 1; the FLUSH state is never entered otherwise.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 2);

  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic [size-1:0] r_redirect_pc;
  logic            w_resolve, w_ctl, w_mis, w_mis_ev;
  logic [size-1:0] w_target, w_jalr_sum;

  assign w_resolve  = ex_valid && (r_state == IDLE);
  assign w_jalr_sum = ex_rs1 + ex_imm;

  // JALR > JAL > branch when several type flags are set.
  always_comb begin
    w_ctl    = 1'b0;
    w_mis    = 1'b0;
    w_target = ex_pc + 4;
    if (ex_is_jalr) begin
      w_ctl    = 1'b1;
      w_mis    = 1'b1;
      w_target = {w_jalr_sum[size-1:1], 1'b0};
    end else if (ex_is_jal) begin
      w_ctl    = 1'b1;
      w_mis    = !ex_pred_taken;
      w_target = ex_pc + ex_imm;
    end else if (ex_is_branch) begin
      w_ctl    = 1'b1;
      w_mis    = (ex_cond != ex_pred_taken);
      w_target = ex_cond ? (ex_pc + ex_imm) : (ex_pc + 4);
    end
  end

  assign w_mis_ev = w_resolve && w_ctl && w_mis;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_mis_ev) w_next = REDIRECT;
      REDIRECT: w_next = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
      FLUSH:    if (r_cnt == 4'd0) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == REDIRECT)
        r_cnt <= CNT_INIT;
      else if (r_state == FLUSH && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_mis_ev)
        r_redirect_pc <= w_target;
    end
  end

  // Outputs decode the async-reset state register, so reset clears them at once.
  assign redirect_valid = (r_state == REDIRECT);
  assign flush_if       = (r_state != IDLE);
  assign flush_id       = (r_state != IDLE);
  assign busy           = (r_state != IDLE);
  assign redirect_pc    = r_redirect_pc;

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_res, r_stat_mis;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_res <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_resolve && w_ctl && r_stat_res != 32'hFFFF_FFFF)
        r_stat_res <= r_stat_res + 32'd1;
      if (w_mis_ev && r_stat_mis != 32'hFFFF_FFFF)
        r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_resolved   = r_stat_res;
  assign stat_mispredict = r_stat_mis;
`else
  assign stat_resolved   = 32'd0;
  assign stat_mispredict = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases plus random traffic
// against a window-counting reference model.
module tb_branch_resolve_unit;
  parameter int FC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 0, ex_is_branch = 0, ex_is_jal = 0, ex_is_jalr = 0;
  logic        ex_pred_taken = 0, ex_cond = 0;
  logic [31:0] ex_pc = 0, ex_imm = 0, ex_rs1 = 0;
  logic        redirect_valid, flush_if, flush_id, busy;
  logic [31:0] redirect_pc, stat_resolved, stat_mispredict;

  branch_resolve_unit #(.size(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_pred_taken(ex_pred_taken),
    .ex_cond(ex_cond), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if(flush_if),
    .flush_id(flush_id), .busy(busy), .stat_resolved(stat_resolved),
    .stat_mispredict(stat_mispredict));

  always #5 clk = ~clk;

  typedef struct { int tag; bit rv; bit fl; logic [31:0] sr; logic [31:0] sm; } st_t;
  typedef struct { int tag; logic [31:0] pc; } rd_t;
  st_t sq[$];
  rd_t rq[$];

  int checks = 0, errors = 0;
  int ecnt = 0;
  int win = 0;                 // cycles of busy window still ahead (0 = idle)
  logic [31:0] m_res = 0, m_mis = 0;

  always @(posedge clk) ecnt++;

  // Reference resolution straight from the architectural rules.
  function automatic void resolve(input bit br, jl, jr, pr, cd, input logic [31:0] pc, imm, rs1,
                                  output bit ctl, output bit mis, output logic [31:0] tgt);
    ctl = 1; mis = 0; tgt = pc + 32'd4;
    if (jr) begin mis = 1; tgt = (rs1 + imm) & ~32'd1; end
    else if (jl) begin mis = !pr; tgt = pc + imm; end
    else if (br) begin mis = (cd != pr); tgt = cd ? pc + imm : pc + 32'd4; end
    else ctl = 0;
  endfunction

  task automatic step(input bit v, br, jl, jr, pr, cd, input logic [31:0] pc, imm, rs1);
    bit ctl, mis, trig;
    logic [31:0] tgt;
    st_t e;
    rd_t r;
    ex_valid = v; ex_is_branch = br; ex_is_jal = jl; ex_is_jalr = jr;
    ex_pred_taken = pr; ex_cond = cd; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    resolve(br, jl, jr, pr, cd, pc, imm, rs1, ctl, mis, tgt);
    trig = 0;
    if (win > 0) win--;
    else if (v && ctl) begin
      if (m_res != 32'hFFFF_FFFF) m_res++;
      if (mis) begin
        trig = 1; win = FC;
        if (m_mis != 32'hFFFF_FFFF) m_mis++;
      end
    end
    e.tag = ecnt + 1; e.rv = trig; e.fl = (win > 0);
`ifdef BRU_STATS_EN
    e.sr = m_res; e.sm = m_mis;
`else
    e.sr = 0; e.sm = 0;
`endif
    sq.push_back(e);
    if (trig) begin r.tag = ecnt + 1; r.pc = tgt; rq.push_back(r); end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents after each edge.
  always begin
    st_t e;
    rd_t r;
    @(posedge clk); #3;
    while (sq.size() > 0 && sq[0].tag <= ecnt) begin
      e = sq.pop_front();
      checks++;
      if (e.tag != ecnt || redirect_valid !== e.rv || flush_if !== e.fl || flush_id !== e.fl ||
          busy !== e.fl || stat_resolved !== e.sr || stat_mispredict !== e.sm) begin
        errors++;
        $display("FAIL status edge %0d: rv=%b fi=%b fd=%b busy=%b sr=%0d sm=%0d, want rv=%b flush/busy=%b sr=%0d sm=%0d (tag %0d)",
                 ecnt, redirect_valid, flush_if, flush_id, busy, stat_resolved, stat_mispredict,
                 e.rv, e.fl, e.sr, e.sm, e.tag);
      end
    end
    if (redirect_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0 || rq[0].tag != ecnt) begin
        errors++;
        $display("FAIL redirect edge %0d: unexpected pulse pc=%h", ecnt, redirect_pc);
      end else begin
        r = rq.pop_front();
        if (redirect_pc !== r.pc) begin
          errors++;
          $display("FAIL redirect_pc edge %0d: got %h want %h", ecnt, redirect_pc, r.pc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    #1;
    chk("reset redirect_valid", {31'd0, redirect_valid}, 0);
    chk("reset flush_if", {31'd0, flush_if}, 0);
    chk("reset flush_id", {31'd0, flush_id}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    chk("reset stat_resolved", stat_resolved, 0);
    chk("reset stat_mispredict", stat_mispredict, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Branch predicted taken, actually not taken.
    step(1, 1, 0, 0, 1, 0, 32'h100, 32'h40, 0);
    idle(FC + 1);
    // Mispredict followed by wrong-path mispredicts that must be ignored.
    step(1, 1, 0, 0, 0, 1, 32'h200, 32'hFFFF_FFF0, 0);
    step(1, 1, 0, 0, 1, 0, 32'h300, 32'h8, 0);
    step(1, 0, 0, 1, 0, 0, 32'h304, 32'h8, 32'h55);
    idle(FC + 1);
    // JALR target with bit0 cleared; correctly predicted JAL.
    step(1, 0, 0, 1, 0, 0, 32'h400, 32'h10, 32'h1001);
    idle(FC);
    step(1, 0, 1, 0, 1, 0, 32'h500, 32'h20, 0);
    // Correct branch, then an ALU op, then a flag-priority case (JALR wins).
    step(1, 1, 0, 0, 1, 1, 32'h600, 32'h80, 0);
    step(1, 0, 0, 0, 0, 0, 32'h604, 0, 0);
    step(1, 1, 1, 1, 1, 1, 32'h700, 32'h4, 32'h2000);
    idle(FC + 1);
    // PC wrap on a not-taken mispredict.
    step(1, 1, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h40, 0);
    idle(FC + 1);

    // Reset asserted inside the flush window.
    step(1, 1, 0, 0, 1, 0, 32'h800, 32'h40, 0);
    idle(FC > 1 ? 1 : 0);
    #3;
    reset = 1'b0;
    #1;
    chk("async reset redirect_valid", {31'd0, redirect_valid}, 0);
    chk("async reset flush_if", {31'd0, flush_if}, 0);
    chk("async reset flush_id", {31'd0, flush_id}, 0);
    chk("async reset busy", {31'd0, busy}, 0);
    sq.delete(); rq.delete();
    win = 0; m_res = 0; m_mis = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    step(1, 1, 0, 0, 0, 1, 32'h900, 32'h40, 0);
    idle(FC + 1);

    // Random traffic, including overlapping type flags.
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] k;
      k = 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 8, k[0], k[1], k[2], 1'($urandom), 1'($urandom),
           $urandom & ~32'd3, $urandom, $urandom);
    end
    idle(FC + 2);
    #5;
    checks++;
    if (sq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d status and %0d redirect entries left, want 0", sq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage counterpart to the decode-stage static predictor.
- The predictor guesses taken for JAL and conditional branches. This block resolves the actual outcome in EX, detects mispredictions, and issues a registered PC redirect.
- On a misprediction it holds a flush of the IF/ID pipeline registers for a fixed window and discards wrong-path EX traffic during that window.

Parameters:
- size, 32, datapath/PC width.
- FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high after a misprediction; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX stage holds a valid instruction this cycle.
- ex_is_branch  input  1  EX instruction is a conditional branch (opcode 1100011).
- ex_is_jal  input  1  EX instruction is JAL (opcode 1101111).
- ex_is_jalr  input  1  EX instruction is JALR (opcode 1100111).
- ex_pred_taken  input  1  prediction bit carried down from ID.
- ex_cond  input  1  branch comparator result, 1 = taken.
- ex_pc  input  size  PC of EX instruction.
- ex_imm  input  size  sign-extended immediate.
- ex_rs1  input  size  rs1 operand, used for the JALR target.
- redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  output  size  corrected fetch address.
- flush_if  output  1  squash IF/ID register.
- flush_id  output  1  squash ID/EX register.
- busy  output  1  block is in REDIRECT or FLUSH.
- stat_resolved  output  32  count of resolved control-flow instructions (feature only).
- stat_mispredict  output  32  count of mispredictions (feature only).

Behaviour:
- Reset (reset=0, async): state=IDLE; redirect_valid, flush_if, flush_id, busy = 0; redirect_pc = 0; stat counters = 0.
- Resolution: an instruction is resolved only when ex_valid=1 and state=IDLE.
- Actual taken:
  - Conditional branch: ex_cond.
  - JAL: 1.
  - JALR: 1.
- Correct target (all sums modulo 2^size; wrap-around is ignored):
  - Taken branch or JAL: ex_pc+ex_imm.
  - Not-taken branch: ex_pc+4.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared.
- Mispredict conditions:
  - Branch: ex_cond != ex_pred_taken.
  - JAL: ex_pred_taken == 0.
  - JALR: always (no target is predicted).
- Non-control instructions never mispredict. If more than one ex_is_* flag is high, priority is JALR > JAL > branch.
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE -> REDIRECT on a mispredict detected in cycle N. redirect_pc is registered at the N edge.
  - REDIRECT, cycle N+1: redirect_valid=1, flush_if=1, flush_id=1, busy=1. Goes to FLUSH if FLUSH_CYCLES>1, otherwise to IDLE.
  - FLUSH: flush_if=flush_id=1, busy=1, redirect_valid=0. A 4-bit down-counter loaded with FLUSH_CYCLES-2 returns the FSM to IDLE when it reaches 0.
- Total flush window: exactly FLUSH_CYCLES cycles, N+1..N+FLUSH_CYCLES. redirect_valid is high only in N+1.
- Back-to-back resolution: the first cycle back in IDLE may resolve a new instruction immediately.
- While busy: ex_valid is ignored. No resolution, no counter update, no re-trigger, even if the EX instruction would mispredict (it is wrong-path).
- Correct prediction: no output activity; state stays IDLE.
- Reset asserted mid-REDIRECT/FLUSH: outputs drop to 0 immediately (asynchronously); FSM returns to IDLE.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined:
  - stat_resolved increments on every resolution of a branch, JAL or JALR.
  - stat_mispredict increments on every detected mispredict.
  - Both saturate at 32'hFFFFFFFF and clear only on reset.
- Not defined: counters are not synthesized; both stat ports are driven constant 0.

Test Plan:
- Branch at ex_pc=0x100, ex_imm=0x40, pred=1, cond=0 -> redirect_valid pulse at N+1 with redirect_pc=0x104; flush_if/flush_id high for N+1..N+2 (FLUSH_CYCLES=2); busy low at N+3.
- Branch at ex_pc=0x200, imm=0xFFFFFFF0, pred=0, cond=1 -> redirect_pc=0x1F0; a second mispredicting branch presented at N+1 and N+2 is ignored; stat_mispredict=1 (BRU_STATS_EN).
- JALR with ex_rs1=0x1001, ex_imm=0x10, pred=0 -> redirect_pc=0x1010 (bit0 cleared); JAL with pred=1 -> no redirect, stat_resolved increments.
- Correctly predicted branch (pred=1, cond=1) followed by an ALU op -> redirect_valid, flush_if and busy stay 0 throughout.
- Reset driven low during FLUSH state -> flush_if, flush_id, busy = 0 in the same cycle (before the next clock edge); after release, a new mispredict produces a normal pulse sequence.
- FLUSH_CYCLES=1 build: mispredict -> single cycle with redirect_valid=flush_if=flush_id=1, back to IDLE at N+2; PC wrap case ex_pc=0xFFFFFFFC, not-taken mispredict -> redirect_pc=0x00000000.
